// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the unified memory-port arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWN_IMEM = 1'b0;
  localparam logic OWN_DMEM = 1'b1;

  localparam logic [3:0] MASK_FULL = 4'b1111;
endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner selection: data first, fetch once the data streak hits its limit
module mem_arb_pick (
  input  logic imem_pend,
  input  logic dmem_pend,
  input  logic streak_lim,
  output logic grant_i,
  output logic grant_d
);
  assign grant_d = dmem_pend & ~(imem_pend & streak_lim);
  assign grant_i = imem_pend & ~grant_d;
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-outstanding arbiter sharing a variable-latency memory port between fetch and data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_req,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_ready,
  output logic        o_imem_valid,
  output logic [31:0] o_imem_rdata,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_mem_req,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);
  logic [1:0]  state, state_nxt;
  logic [2:0]  streak;
  logic        own_q, ren_q, wen_q;
  logic [31:0] addr_q, wdata_q, imem_rdata_q, dmem_rdata_q;
  logic [3:0]  mask_q;
  logic        dmem_pend, streak_lim, grant_i, grant_d, accept;
  logic        unused_addr_lsb;

  // Both ren and wen high is malformed and never counts as a pending request.
  assign dmem_pend       = i_dmem_ren ^ i_dmem_wen;
  assign streak_lim      = (streak == 3'(DATA_STREAK_MAX));
  assign accept          = (state == ST_IDLE) & ~i_rst & (grant_i | grant_d);
  assign unused_addr_lsb = ^{i_imem_addr[1:0], i_dmem_addr[1:0]};

  mem_arb_pick u_pick (
    .imem_pend  (i_imem_req),
    .dmem_pend  (dmem_pend),
    .streak_lim (streak_lim),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)      state_nxt = ST_ISSUE;
      ST_ISSUE: if (i_mem_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (i_mem_valid) state_nxt = ST_RESP;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      streak       <= 3'd0;
      own_q        <= OWN_IMEM;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      mask_q       <= 4'h0;
      imem_rdata_q <= 32'h0;
      dmem_rdata_q <= 32'h0;
    end else begin
      if (accept && grant_i) begin
        streak  <= 3'd0;
        own_q   <= OWN_IMEM;
        addr_q  <= {i_imem_addr[31:2], 2'b00};
        ren_q   <= 1'b1;
        wen_q   <= 1'b0;
        wdata_q <= 32'h0;
        mask_q  <= MASK_FULL;
      end else if (accept) begin
        if (i_imem_req && !streak_lim) streak <= streak + 3'd1;
        own_q   <= OWN_DMEM;
        addr_q  <= {i_dmem_addr[31:2], 2'b00};
        ren_q   <= i_dmem_ren;
        wen_q   <= i_dmem_wen;
        wdata_q <= i_dmem_wdata;
        mask_q  <= i_dmem_mask;
      end
      if (state == ST_WAIT && i_mem_valid) begin
        if (own_q == OWN_IMEM) imem_rdata_q <= i_mem_rdata;
        else                   dmem_rdata_q <= wen_q ? 32'h0 : i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_imem_ready = accept & grant_i;
    o_dmem_ready = accept & grant_d;
    o_mem_req    = (state == ST_ISSUE);
    o_mem_ren    = o_mem_req & ren_q;
    o_mem_wen    = o_mem_req & wen_q;
    o_mem_addr   = addr_q;
    o_mem_wdata  = wdata_q;
    o_mem_mask   = mask_q;
    o_imem_valid = (state == ST_RESP) & (own_q == OWN_IMEM);
    o_dmem_valid = (state == ST_RESP) & (own_q == OWN_DMEM);
    o_imem_rdata = imem_rdata_q;
    o_dmem_rdata = dmem_rdata_q;
  end
endmodule
